// File: rtl/amdc_leds_pkg.sv
// Shared definitions for the LED chain frame sequencer: word width,
// default latch length and the sequencer state encoding.
package amdc_leds_pkg;

    localparam int LED_WORD_W           = 24;
    localparam int DEFAULT_RESET_CYCLES = 20000;

    // IDLE must stay at zero so a cleared state register means "not busy".
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_START   = 3'd3,
        ST_WAIT_LO = 3'd4,
        ST_WAIT_HI = 3'd5,
        ST_LATCH   = 3'd6
    } seq_state_e;

endpackage

// File: rtl/led_latch_timer.sv
// Loadable up-counter that times the latch/reset low period of the LED line.
// start_i clears the count; while run_i is high it counts up and holds at
// CYCLES-1, where expired_o is raised.
module led_latch_timer
    import amdc_leds_pkg::*;
#(
    parameter int CYCLES = DEFAULT_RESET_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic run_i,
    output logic expired_o
);

    localparam int CW = $clog2(CYCLES);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired_o = (cnt_q == CW'(CYCLES - 1));

    // Next count: clear on start, otherwise advance until the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = '0;
        end else if (run_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_frame_sequencer.sv
// Frame-level controller for the LED chain. Holds one colour word per LED,
// and on trigger streams every word MSB first through the line driver's
// start/code/done handshake, then holds the line low for the latch period.
//
// Line driver handshake: ld_done high means the driver is free. ld_start is
// a one-cycle request carrying ld_code; the driver drops ld_done after it
// samples ld_start and raises it again when the bit has been sent. ld_code
// is held from the start cycle until ld_done rises.
module led_frame_sequencer
    import amdc_leds_pkg::*;
#(
    parameter  int N_LEDS       = 8,
    parameter  int RESET_CYCLES = DEFAULT_RESET_CYCLES,
    localparam int AW           = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [LED_WORD_W-1:0] wr_data,
    input  logic                  trigger,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  ld_code,
    output logic                  ld_start,
    input  logic                  ld_done
);

    seq_state_e            state_q, state_d;
    logic [AW-1:0]         led_idx_q, led_idx_d;
    logic [4:0]            bit_cnt_q, bit_cnt_d;
    logic [LED_WORD_W-1:0] shreg_q, shreg_d;
    logic                  pending_q, pending_d;
    logic [LED_WORD_W-1:0] colour_q [N_LEDS];

    logic                  latch_start;
    logic                  latch_expired;
    logic                  last_led;
    logic                  wr_in_range;
    logic [AW:0]           wr_addr_ext;

    // Widen by one bit so the range check is meaningful for any N_LEDS.
    assign wr_addr_ext = {1'b0, wr_addr};
    assign wr_in_range = (wr_addr_ext < (AW + 1)'(N_LEDS));
    assign last_led    = (led_idx_q == AW'(N_LEDS - 1));

    // Colour array: written from the host side at any time, in-range only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_LEDS; i++) begin
                colour_q[i] <= '0;
            end
        end else if (wr_en && wr_in_range) begin
            colour_q[wr_addr] <= wr_data;
        end
    end

    led_latch_timer #(
        .CYCLES (RESET_CYCLES)
    ) u_latch_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (latch_start),
        .run_i     (state_q == ST_LATCH),
        .expired_o (latch_expired)
    );

    // Next-state logic: bit/LED sequencing and the single pending request.
    always_comb begin
        state_d     = state_q;
        led_idx_d   = led_idx_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        pending_d   = pending_q;
        latch_start = 1'b0;

        // Extra triggers while a frame runs collapse into one request.
        if (trigger && (state_q != ST_IDLE)) begin
            pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (trigger || pending_q) begin
                    state_d   = ST_LOAD;
                    led_idx_d = '0;
                    pending_d = 1'b0;
                end
            end
            ST_LOAD: begin
                shreg_d   = colour_q[led_idx_q];
                bit_cnt_d = 5'(LED_WORD_W - 1);
                state_d   = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (ld_done) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                if (!ld_done) begin
                    state_d = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (ld_done) begin
                    if (bit_cnt_q != 5'd0) begin
                        shreg_d   = {shreg_q[LED_WORD_W-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q - 5'd1;
                        state_d   = ST_ISSUE;
                    end else if (last_led) begin
                        // Clearing shreg keeps the code line low while latching.
                        shreg_d     = '0;
                        latch_start = 1'b1;
                        state_d     = ST_LATCH;
                    end else begin
                        led_idx_d = led_idx_q + 1'b1;
                        state_d   = ST_LOAD;
                    end
                end
            end
            ST_LATCH: begin
                if (latch_expired) begin
                    if (pending_q) begin
                        // Back-to-back frame without passing through IDLE.
                        state_d   = ST_LOAD;
                        led_idx_d = '0;
                        pending_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            led_idx_q <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            led_idx_q <= led_idx_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            pending_q <= pending_d;
        end
    end

    // Outputs decode registered state only.
    assign busy       = (state_q != ST_IDLE);
    assign ld_start   = (state_q == ST_START);
    assign ld_code    = shreg_q[LED_WORD_W-1];
    assign frame_done = (state_q == ST_LATCH) && latch_expired;

endmodule

// File: doc/led_frame_sequencer.md
# led_frame_sequencer

Frame-level controller for the IN-PI556FCH LED chain on the 200 MHz fabric clock. Holds one 24-bit colour word per LED in a register array written by the AXI-side logic. On `trigger` it streams every word, MSB first, one bit at a time, through the bit-level line driver's `start`/`code`/`done` handshake. It then holds the line low for the latch/reset period. The block owns sequencing only; the line waveform timing belongs to the line driver instance it controls.

## Interface
- `N_LEDS`, default 8: number of LEDs in chain; ≥1.
- `RESET_CYCLES`, default 20000: latch low time in clk cycles (100 µs at 200 MHz); ≥2.
- `clk` in 1: 200 MHz clock.
- `rst_n` in 1: asynchronous active-low reset.
- `wr_en` in 1: colour write strobe.
- `wr_addr` in AW=max(1,$clog2(N_LEDS)): LED index.
- `wr_data` in 24: colour word; bit 23 is transmitted first.
- `trigger` in 1: one-cycle request to send a frame.
- `busy` out 1: frame or latch in progress.
- `frame_done` out 1: one-cycle pulse at end of latch period.
- `ld_code` out 1: bit value to the line driver.
- `ld_start` out 1: start to the line driver.
- `ld_done` in 1: line driver free (high when idle).
- One clock; reset is asynchronous and active-low (`clk`, `rst_n`).

## Operation
- Colour array: `N_LEDS` × 24 registers, reset to 0.
  - `wr_en` with `wr_addr < N_LEDS` writes on the clk edge. Out-of-range addresses are ignored.
  - Writes are accepted at any time, including while `busy`.
  - A word is sampled into the shift register only in LOAD. A write to an LED that has not yet been loaded therefore appears in the current frame; a write to an LED already loaded appears in the next frame.
- Pending trigger flag:
  - Set by `trigger` while `busy`; only one request is held, extra triggers are merged.
  - Cleared when a frame starts from it.
- States:
  - IDLE: `busy`=0. Moves to LOAD on `trigger` or pending; clears `led_idx` to 0.
  - LOAD: `shreg`←array[`led_idx`], `bit_cnt`←23. Next state is ISSUE.
  - ISSUE: waits for `ld_done`=1, then goes to START.
  - START: `ld_start`=1 for exactly this cycle. Next state is WAIT_LO.
  - WAIT_LO: waits for `ld_done`=0 (the driver drops done one cycle after sampling start), then goes to WAIT_HI.
  - WAIT_HI: waits for `ld_done`=1.
    - If `bit_cnt`≠0: shift `shreg` left 1, decrement `bit_cnt`, go to ISSUE.
    - Else if `led_idx`=N_LEDS−1: clear the latch counter, go to LATCH.
    - Else: increment `led_idx`, go to LOAD.
  - LATCH: counts to `RESET_CYCLES`−1, then pulses `frame_done`.
    - Goes to LOAD if pending (clearing pending and `led_idx`), else to IDLE.
- Outputs:
  - `ld_code` = `shreg[23]`; stable from START until the bit completes. `shreg` is cleared to 0 on entering LATCH, so `ld_code`=0 there.
  - `ld_start` and `frame_done` are decoded from registered state and counter only; no input-to-output combinational path.
  - `busy` = (state≠IDLE).
- Reset values: state IDLE; `busy`, `ld_start`, `ld_code`, `frame_done`, pending = 0; counters = 0.
- Reset mid-frame aborts immediately with no partial-bit completion. The line driver shares `rst_n`, so both restart clean.
- `ld_done` stuck low: the block waits indefinitely; there is no timeout.

## Timing
- `trigger` at edge k (IDLE) → LOAD k+1 → ISSUE k+2 → `ld_start` high in cycle k+3 (ld_done=1).
- Between bits within an LED: `ld_done` rise sampled in WAIT_HI → ISSUE → START, so `ld_start` is 2 cycles after the rise.
- Between LEDs: 3 cycles (LOAD added).
- LATCH occupies exactly `RESET_CYCLES` cycles. `frame_done` is high in the last LATCH cycle. `busy` falls on the following edge unless a trigger is pending.
- Frame length = 24·N_LEDS bit times + controller overhead + `RESET_CYCLES`.
- Counters:
  - `led_idx` is AW bits; it never wraps because the bound check is explicit.
  - `bit_cnt` is 5 bits.
  - Latch counter is $clog2(RESET_CYCLES) bits.

## Structure
- Shared package `amdc_leds_pkg`:
  - state encoding (3-bit, IDLE=0),
  - `LED_WORD_W`=24,
  - default `RESET_CYCLES`.
- One natural sub-module, `led_latch_timer`:
  - loadable counter with `start` and `expired` outputs,
  - used for LATCH.
- The line driver is instantiated alongside this block in the IP top, not inside it.

## Test plan
- Reset, no trigger → `busy`=0, `ld_start`=0, `ld_code`=0 indefinitely; array reads as 0 (frame of zeros when triggered).
- N_LEDS=2, write LED0=0xA50000, LED1=0x000001, trigger with line driver model:
  - 48 `ld_start` pulses; `ld_code` sequence is 1,0,1,0,0,1,0,1,0×16, then 0×23,1;
  - `frame_done` exactly `RESET_CYCLES` cycles after the 48th `ld_done` rise.
- Cycle check: trigger at cycle k gives `ld_start` at k+3. Each subsequent `ld_start` occurs 2 cycles after a `ld_done` rise (3 cycles at LED boundaries); `ld_code` is held constant between `ld_start` and the `ld_done` rise.
- Triggers while busy:
  - Two triggers during frame 1 → exactly one extra frame, starting from LATCH end with no IDLE cycle.
  - `busy` stays high throughout.
- Write LED1 while LED0 is shifting → new LED1 value sent in the same frame. Write LED0 while LED1 is shifting → old LED0 value stays in this frame, new value in the next.
- `rst_n` low mid-bit:
  - outputs reset asynchronously;
  - after release, trigger gives a complete correct frame;
  - out-of-range `wr_addr` does not modify any word.
